// File: rtl/ddr_ram_port_arbiter.sv
// ddr_ram_port_arbiter
//   Shares one simple dual-port RAM (independent write and read ports, one
//   clock) between NUM_REQ requesters. Each RAM port has its own round-robin
//   arbiter. Granted commands are registered onto the RAM ports. A tag
//   pipeline routes every read return back to the requester that issued it.
//
// Ports
//   clk, rst              single clock, synchronous active-high reset
//   wr_req/wr_addr/wr_data  per-requester write requests (packed, slice i)
//   wr_gnt                one-hot write grant (combinational)
//   rd_req/rd_addr        per-requester read requests (packed, slice i)
//   rd_gnt                one-hot read grant (combinational)
//   rd_valid/rd_data      one-hot read-return strobe and shared return data
//   ram_we/ram_waddr/ram_wdata   registered RAM write command
//   ram_re/ram_raddr      registered RAM read command
//   ram_rdata             RAM read data, valid RD_LATENCY cycles after ram_re
module ddr_ram_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int RD_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               wr_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    wr_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    wr_data,
  output logic [NUM_REQ-1:0]               wr_gnt,
  input  logic [NUM_REQ-1:0]               rd_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    rd_addr,
  output logic [NUM_REQ-1:0]               rd_gnt,
  output logic [NUM_REQ-1:0]               rd_valid,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             ram_we,
  output logic [ADDR_WIDTH-1:0]            ram_waddr,
  output logic [DATA_WIDTH-1:0]            ram_wdata,
  output logic                             ram_re,
  output logic [ADDR_WIDTH-1:0]            ram_raddr,
  input  logic [DATA_WIDTH-1:0]            ram_rdata
);

  localparam int          IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NR    = NUM_REQ;
  localparam int unsigned DEPTH = 1 + RD_LATENCY;

  // Round-robin pick: search upward from last+1 with wrap.
  // Result MSB = a winner exists, low bits = winner index.
  function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                          input logic [IW-1:0]      last);
    logic [IW:0] res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      idx = 32'(last) + k;
      if (idx >= NR) idx = idx - NR;
      if (!res[IW] && req[idx[IW-1:0]]) res = {1'b1, idx[IW-1:0]};
    end
    return res;
  endfunction

  // Pointers hold the last granted index.
  logic [IW-1:0]         wr_last_q, wr_last_d;
  logic [IW-1:0]         rd_last_q, rd_last_d;
  logic [IW:0]           wr_pick, rd_pick;
  logic                  wr_win, rd_win;
  logic [IW-1:0]         wr_idx, rd_idx;

  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_waddr_q, ram_waddr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  ram_re_q, ram_re_d;
  logic [ADDR_WIDTH-1:0] ram_raddr_q, ram_raddr_d;

  // Read tag pipeline: stage 0 lines up with ram_re, the last stage with
  // ram_rdata.
  logic [DEPTH-1:0]      tv_q;
  logic [IW-1:0]         ti_q [DEPTH];

  always_comb begin
    wr_pick = rr_pick(wr_req, wr_last_q);
    rd_pick = rr_pick(rd_req, rd_last_q);
    wr_win  = !rst && wr_pick[IW];
    rd_win  = !rst && rd_pick[IW];
    wr_idx  = wr_pick[IW-1:0];
    rd_idx  = rd_pick[IW-1:0];
    wr_gnt  = wr_win ? (NUM_REQ'(1) << wr_idx) : '0;
    rd_gnt  = rd_win ? (NUM_REQ'(1) << rd_idx) : '0;
  end

  always_comb begin
    wr_last_d   = wr_win ? wr_idx : wr_last_q;
    rd_last_d   = rd_win ? rd_idx : rd_last_q;
    ram_we_d    = wr_win;
    ram_re_d    = rd_win;
    ram_waddr_d = wr_win ? wr_addr[wr_idx*ADDR_WIDTH +: ADDR_WIDTH] : ram_waddr_q;
    ram_wdata_d = wr_win ? wr_data[wr_idx*DATA_WIDTH +: DATA_WIDTH] : ram_wdata_q;
    ram_raddr_d = rd_win ? rd_addr[rd_idx*ADDR_WIDTH +: ADDR_WIDTH] : ram_raddr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_last_q   <= IW'(NUM_REQ - 1);
      rd_last_q   <= IW'(NUM_REQ - 1);
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
      ram_raddr_q <= '0;
    end else begin
      wr_last_q   <= wr_last_d;
      rd_last_q   <= rd_last_d;
      ram_we_q    <= ram_we_d;
      ram_re_q    <= ram_re_d;
      ram_waddr_q <= ram_waddr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_raddr_q <= ram_raddr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tv_q <= '0;
      for (int unsigned s = 0; s < DEPTH; s++) ti_q[s] <= '0;
    end else begin
      tv_q[0] <= rd_win;
      ti_q[0] <= rd_idx;
      for (int unsigned s = 1; s < DEPTH; s++) begin
        tv_q[s] <= tv_q[s-1];
        ti_q[s] <= ti_q[s-1];
      end
    end
  end

  assign ram_we    = ram_we_q;
  assign ram_waddr = ram_waddr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_re    = ram_re_q;
  assign ram_raddr = ram_raddr_q;

  // Return data passes straight through from the RAM; it is gated to zero
  // outside a return strobe so that it reads 0 after reset.
  assign rd_valid = tv_q[DEPTH-1] ? (NUM_REQ'(1) << ti_q[DEPTH-1]) : '0;
  assign rd_data  = tv_q[DEPTH-1] ? ram_rdata : '0;

endmodule

// File: tb/tb_ddr_ram_port_arbiter.sv
// Bench for ddr_ram_port_arbiter: one instance with a registered-output RAM
// (RD_LATENCY=1) and one with a combinational-read RAM (RD_LATENCY=0), both
// fed the same requests and checked every cycle against a transaction-level
// model (round-robin pick, reference memory, per-cycle read-grant history).
module tb_ddr_ram_port_arbiter;
  localparam int N = 2, AW = 9, DW = 8, MAXC = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    wr_req, rd_req;
  logic [N*AW-1:0] wr_addr, rd_addr;
  logic [N*DW-1:0] wr_data;

  logic [N-1:0]  wr_gnt_a, rd_gnt_a, rd_valid_a, wr_gnt_b, rd_gnt_b, rd_valid_b;
  logic [DW-1:0] rd_data_a, ram_wdata_a, ram_rdata_a, rd_data_b, ram_wdata_b, ram_rdata_b;
  logic          ram_we_a, ram_re_a, ram_we_b, ram_re_b;
  logic [AW-1:0] ram_waddr_a, ram_raddr_a, ram_waddr_b, ram_raddr_b;

  ddr_ram_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1)) u_a (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_gnt(wr_gnt_a), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt_a),
    .rd_valid(rd_valid_a), .rd_data(rd_data_a), .ram_we(ram_we_a), .ram_waddr(ram_waddr_a),
    .ram_wdata(ram_wdata_a), .ram_re(ram_re_a), .ram_raddr(ram_raddr_a), .ram_rdata(ram_rdata_a));

  ddr_ram_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(0)) u_b (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_gnt(wr_gnt_b), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt_b),
    .rd_valid(rd_valid_b), .rd_data(rd_data_b), .ram_we(ram_we_b), .ram_waddr(ram_waddr_b),
    .ram_wdata(ram_wdata_b), .ram_re(ram_re_b), .ram_raddr(ram_raddr_b), .ram_rdata(ram_rdata_b));

  // RAM with output register (read-before-write)
  logic [DW-1:0] mem_a [512];
  logic [DW-1:0] rdq_a;
  always @(posedge clk) begin
    if (ram_re_a) rdq_a <= mem_a[ram_raddr_a];
    if (ram_we_a) mem_a[ram_waddr_a] <= ram_wdata_a;
  end
  assign ram_rdata_a = rdq_a;

  // RAM with combinational read
  logic [DW-1:0] mem_b [512];
  always @(posedge clk) if (ram_we_b) mem_b[ram_waddr_b] <= ram_wdata_b;
  assign ram_rdata_b = mem_b[ram_raddr_b];

  // Model state
  logic [DW-1:0] mref [512];
  int            wlast, rlast, last_gw, last_gr, cyc;
  bit            armed;
  logic          e_we, e_re;
  logic [AW-1:0] e_waddr, e_raddr;
  logic [DW-1:0] e_wdata;
  int            hist_idx [MAXC];
  logic [DW-1:0] hist_dat [MAXC];
  int            n_chk, n_pass;

  function automatic int rr(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
  endtask

  task automatic model_step();
    int gw, gr, due;
    gw = rst ? -1 : rr(wr_req, wlast);
    gr = rst ? -1 : rr(rd_req, rlast);
    chk("wr_gnt_a", 32'(wr_gnt_a), 32'(oh(gw)));
    chk("rd_gnt_a", 32'(rd_gnt_a), 32'(oh(gr)));
    chk("wr_gnt_b", 32'(wr_gnt_b), 32'(oh(gw)));
    chk("rd_gnt_b", 32'(rd_gnt_b), 32'(oh(gr)));
    if (armed) begin
      chk("ram_we", 32'(ram_we_a), 32'(e_we));
      chk("ram_re", 32'(ram_re_a), 32'(e_re));
      chk("ram_waddr", 32'(ram_waddr_a), 32'(e_waddr));
      chk("ram_wdata", 32'(ram_wdata_a), 32'(e_wdata));
      chk("ram_raddr", 32'(ram_raddr_a), 32'(e_raddr));
      due = (cyc >= 2) ? hist_idx[cyc-2] : -1;
      chk("rd_valid_a", 32'(rd_valid_a), 32'(oh(due)));
      if (due >= 0) chk("rd_data_a", 32'(rd_data_a), 32'(hist_dat[cyc-2]));
      due = (cyc >= 1) ? hist_idx[cyc-1] : -1;
      chk("rd_valid_b", 32'(rd_valid_b), 32'(oh(due)));
      if (due >= 0) chk("rd_data_b", 32'(rd_data_b), 32'(hist_dat[cyc-1]));
    end
    // A read sees every write granted in earlier cycles, not this one.
    hist_idx[cyc] = gr;
    if (gr >= 0) hist_dat[cyc] = mref[rd_addr[gr*AW +: AW]];
    if (gw >= 0) mref[wr_addr[gw*AW +: AW]] = wr_data[gw*DW +: DW];
    if (rst) begin
      e_we = 1'b0; e_re = 1'b0; e_waddr = '0; e_wdata = '0; e_raddr = '0;
      wlast = N - 1; rlast = N - 1;
      if (cyc >= 1) hist_idx[cyc-1] = -1;
      armed = 1'b1;
    end else begin
      e_we = (gw >= 0);
      e_re = (gr >= 0);
      if (gw >= 0) begin
        e_waddr = wr_addr[gw*AW +: AW]; e_wdata = wr_data[gw*DW +: DW]; wlast = gw;
      end
      if (gr >= 0) begin
        e_raddr = rd_addr[gr*AW +: AW]; rlast = gr;
      end
    end
    last_gw = gw; last_gr = gr;
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0, c1;
    n_chk = 0; n_pass = 0; cyc = 0; armed = 1'b0;
    wlast = N - 1; rlast = N - 1; last_gw = -1; last_gr = -1;
    for (int i = 0; i < MAXC; i++) hist_idx[i] = -1;
    for (int i = 0; i < 512; i++) begin
      mem_a[i] = '0; mem_b[i] = '0; mref[i] = '0;
    end
    rst = 1'b1; wr_req = '0; rd_req = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    @(posedge clk); #1;
    cycle(); cycle();
    rst = 1'b0;

    // Reset flush: read from r1 granted, then reset the next cycle
    rd_req = 2'b10; rd_addr[1*AW +: AW] = 9'h010;
    cycle();
    rd_req = '0; rst = 1'b1;
    cycle();
    chk("flush_valid", 32'(rd_valid_a), 32'h0);
    chk("flush_we", 32'(ram_we_a), 32'h0);
    chk("flush_re", 32'(ram_re_a), 32'h0);
    chk("flush_rdata", 32'(rd_data_a), 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("flush_valid_hold", 32'(rd_valid_a), 32'h0);
    end

    // Write/read round trip
    wr_req = 2'b01; wr_addr[0 +: AW] = 9'h01F; wr_data[0 +: DW] = 8'hA5;
    cycle();
    chk("rt_we", 32'(ram_we_a), 32'h1);
    chk("rt_waddr", 32'(ram_waddr_a), 32'h01F);
    chk("rt_wdata", 32'(ram_wdata_a), 32'hA5);
    wr_req = '0; rd_req = 2'b01; rd_addr[0 +: AW] = 9'h01F;
    cycle();
    chk("rt_re", 32'(ram_re_a), 32'h1);
    chk("rt_raddr", 32'(ram_raddr_a), 32'h01F);
    chk("rt_lat0_valid", 32'(rd_valid_b), 32'h1);
    chk("rt_lat0_data", 32'(rd_data_b), 32'hA5);
    rd_req = '0;
    cycle();
    chk("rt_valid", 32'(rd_valid_a), 32'h1);
    chk("rt_data", 32'(rd_data_a), 32'hA5);

    // Round-robin fairness from a fresh pointer
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    c0 = 0; c1 = 0;
    wr_addr = {9'h0C1, 9'h0C0}; wr_data = {8'h61, 8'h60};
    for (int k = 0; k < 8; k++) begin
      wr_req = 2'b11;
      #1;
      chk("fair_seq", 32'(wr_gnt_a), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (wr_gnt_a[0]) c0++;
      if (wr_gnt_a[1]) c1++;
      cycle();
    end
    wr_req = '0;
    chk("fair_cnt0", 32'(c0), 32'd4);
    chk("fair_cnt1", 32'(c1), 32'd4);

    // Return routing
    wr_req = 2'b10; wr_addr[1*AW +: AW] = 9'h002; wr_data[1*DW +: DW] = 8'h22;
    cycle();
    wr_req = 2'b01; wr_addr[0 +: AW] = 9'h001; wr_data[0 +: DW] = 8'h11;
    cycle();
    wr_req = '0; rd_req = 2'b10; rd_addr[1*AW +: AW] = 9'h002;
    cycle();
    rd_req = 2'b01; rd_addr[0 +: AW] = 9'h001;
    cycle();
    rd_req = '0;
    chk("route_v1", 32'(rd_valid_a), 32'h2);
    chk("route_d1", 32'(rd_data_a), 32'h22);
    cycle();
    chk("route_v0", 32'(rd_valid_a), 32'h1);
    chk("route_d0", 32'(rd_data_a), 32'h11);

    // Same-cycle collision returns old data; a later read sees new data
    wr_req = 2'b01; wr_addr[0 +: AW] = 9'h005; wr_data[0 +: DW] = 8'h33;
    cycle();
    wr_data[0 +: DW] = 8'h44; rd_req = 2'b01; rd_addr[0 +: AW] = 9'h005;
    cycle();
    wr_req = '0;
    cycle();
    rd_req = '0;
    chk("coll_old", 32'(rd_data_a), 32'h33);
    cycle();
    chk("coll_new", 32'(rd_data_a), 32'h44);

    // Randomized traffic with handshake, withdrawals and occasional reset
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) begin
        if (last_gw == i) wr_req[i] = 1'b0;
        else if (wr_req[i] && $urandom_range(15) == 0) wr_req[i] = 1'b0;
        else if (!wr_req[i] && $urandom_range(3) != 0) begin
          wr_req[i] = 1'b1;
          wr_addr[i*AW +: AW] = 9'($urandom_range(15));
          wr_data[i*DW +: DW] = 8'($urandom);
        end
        if (last_gr == i) rd_req[i] = 1'b0;
        else if (rd_req[i] && $urandom_range(15) == 0) rd_req[i] = 1'b0;
        else if (!rd_req[i] && $urandom_range(3) != 0) begin
          rd_req[i] = 1'b1;
          rd_addr[i*AW +: AW] = 9'($urandom_range(15));
        end
      end
      rst = ($urandom_range(299) == 0);
      cycle();
    end
    rst = 1'b0; wr_req = '0; rd_req = '0;
    for (int k = 0; k < 4; k++) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ddr_ram_port_arbiter.md
Name: ddr_ram_port_arbiter

Overview:
- Shares one simple dual-port RAM (independent write and read ports, single clock) between NUM_REQ requesters.
- Write port and read port have independent round-robin arbiters.
- Granted commands are registered onto the RAM ports.
- A tag pipeline routes each read return back to the requester that issued it.
- Sits between the memory-tester traffic generators and the on-chip RAM.

Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..8.
- DATA_WIDTH, 8: RAM data width.
- ADDR_WIDTH, 9: RAM address width.
- RD_LATENCY, 1: cycles from ram_re high to ram_rdata valid. Set 1 when the RAM output register is enabled, 0 when disabled.

Ports:
- clk  in  1  single clock for arbiter and RAM
- rst  in  1  synchronous, active-high reset
- wr_req  in  NUM_REQ  per-requester write request
- wr_addr  in  NUM_REQ*ADDR_WIDTH  packed write addresses, requester i at slice i
- wr_data  in  NUM_REQ*DATA_WIDTH  packed write data
- wr_gnt  out  NUM_REQ  one-hot write grant, combinational
- rd_req  in  NUM_REQ  per-requester read request
- rd_addr  in  NUM_REQ*ADDR_WIDTH  packed read addresses
- rd_gnt  out  NUM_REQ  one-hot read grant, combinational
- rd_valid  out  NUM_REQ  one-hot read-return strobe
- rd_data  out  DATA_WIDTH  read return data, shared by all requesters
- ram_we  out  1  RAM write enable
- ram_waddr  out  ADDR_WIDTH  RAM write address
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_re  out  1  RAM read enable
- ram_raddr  out  ADDR_WIDTH  RAM read address
- ram_rdata  in  DATA_WIDTH  RAM read data

Behaviour:
- Reset (rst high at a clk edge):
  - ram_we, ram_re, ram_waddr, ram_wdata, ram_raddr and rd_data go to 0.
  - rd_valid goes to 0.
  - Both round-robin pointers set so requester 0 has highest priority next.
  - All read tags in flight are cleared; their returns are dropped and never strobed.
  - wr_gnt and rd_gnt are forced to 0 while rst is high.
- Handshake:
  - Requester holds req, addr and data stable until it samples its gnt high at a clk edge.
  - The grant consumes the request. The requester may present a new request in the next cycle, so back-to-back grants at 1 per cycle per port are possible.
  - Dropping req before the grant withdraws the request with no side effects.
- Arbitration (write and read identical, fully independent):
  - gnt is combinational from req and the pointer register.
  - Search starts at (last_granted + 1) mod NUM_REQ, upward with wrap; the first requester with req high wins.
  - At most one gnt bit is high; gnt is 0 when no req is high.
  - The pointer updates to the winner only on cycles with a grant; otherwise it holds.
  - With continuous requests from all requesters, each is granted exactly once per NUM_REQ grants.
- Command issue:
  - A grant in cycle N produces ram_we/ram_re high in cycle N+1, with the winner's addr/data registered.
  - Enables are low in cycle N+1 when there was no grant in cycle N.
  - ram_waddr, ram_wdata and ram_raddr hold their last values when the enables are low.
- Read return:
  - A tag (winner index plus valid bit) travels a shift pipeline of depth 1+RD_LATENCY.
  - rd_valid[i] is high in cycle N+1+RD_LATENCY for a read granted in cycle N, and is high for exactly 1 cycle per granted read.
  - rd_data is registered-through: it equals ram_rdata in that cycle, routed combinationally from ram_rdata.
  - Returns are in grant order. The pipeline accepts 1 read per cycle without stall; there is no backpressure on returns.
- Hazards:
  - Write and read to the same address issued in the same cycle: the read returns the old data. This is the RAM's read-before-write behaviour and is not corrected.
  - A read granted one cycle or more after a write is granted to the same address returns the new data.
- Simultaneous write and read grants in one cycle are legal, including to the same requester.
- Reset asserted mid-burst: grants stop immediately and the pipeline is flushed. The first grant after rst deasserts goes to the lowest-index requester with req high.

Test Plan:
- Reset flush: grant a read from requester 1 to addr 0x010, then assert rst the next cycle → rd_valid stays 0 for 5 cycles; after release, ram_we=ram_re=0 and rd_data=0.
- Write/read round trip (NUM_REQ=2, RD_LATENCY=1): requester 0 writes 0xA5 to 0x01F and is granted in cycle N; requester 0 reads 0x01F, granted in cycle N+1 → ram_we in N+1, ram_re in N+2, rd_valid=2'b01 with rd_data=0xA5 in N+3.
- Round-robin fairness: requesters 0 and 1 hold wr_req continuously for 8 cycles → wr_gnt sequence 01,10,01,10,01,10,01,10; exactly 4 grants each.
- Return routing: back-to-back reads granted r1@0x002 (RAM=0x22), r0@0x001 (RAM=0x11) → rd_valid 10 then 01 on consecutive cycles, rd_data 0x22 then 0x11.
- Same-cycle collision: addr 0x005 holds 0x33; write 0x44 and read 0x005 granted in the same cycle → read returns 0x33; a later read returns 0x44.
- RD_LATENCY=0 build: read granted in cycle N → rd_valid in N+1, coincident with ram_re.
